// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: run / single-step / halt sequencing, load-use
// stall and bubble generation, taken-branch flush, and saturating event counters.
module pipeline_sequencer #(
  parameter logic [5:0] HALT_OPCODE  = 6'h3F,
  parameter int         DRAIN_CYCLES = 3,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_pcsrc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic hazard;
  logic halt_dec;
  logic stall_hit;

  assign hazard = id_ex_memread && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_instr[25:21]) || (id_ex_rt == if_id_instr[20:16]));
  assign halt_dec = (if_id_instr[31:26] == HALT_OPCODE);

  // Mealy controls: a taken branch outranks a stall, which outranks a halt hold.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    flush        = 1'b0;
    stall_hit    = 1'b0;
    case (state_q)
      S_RUN, S_STEP: begin
        if (ex_mem_pcsrc) begin
          flush        = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = 1'b0;
        end else if (hazard) begin
          stall_hit = 1'b1;
        end else if (!(halt_dec && (state_q == S_RUN))) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = 1'b0;
        end
      end
      S_DRAIN: begin
        if (ex_mem_pcsrc) begin
          flush    = 1'b1;
          pc_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (run_req)       state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_STEP: state_d = S_IDLE;
      S_RUN: begin
        if (halt_dec && !ex_mem_pcsrc) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        // A taken branch during drain means the halt was fetched down the wrong path.
        if (ex_mem_pcsrc) begin
          state_d = S_RUN;
          drain_d = '0;
        end else if (drain_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_hit && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    if (flush && (flush_count_q != '1))     flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drain_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign running     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign halted      = (state_q == S_HALTED);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipeline_sequencer;
  localparam logic [5:0] HALT_OP  = 6'h3F;
  localparam int         DRAIN_N  = 3;
  localparam int         CW_SMALL = 3;
  localparam int         MAX_BIG  = 65535;
  localparam int         MAX_SML  = (1 << CW_SMALL) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req, step_req, id_ex_memread, ex_mem_pcsrc;
  logic [31:0] if_id_instr;
  logic [4:0]  id_ex_rt;

  logic        pc_write, if_id_write, id_ex_bubble, flush, running, halted;
  logic [15:0] stall_count, flush_count;
  logic        s_pc_write, s_if_id_write, s_id_ex_bubble, s_flush, s_running, s_halted;
  logic [CW_SMALL-1:0] s_stall_count, s_flush_count;

  pipeline_sequencer #(.HALT_OPCODE(HALT_OP), .DRAIN_CYCLES(DRAIN_N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
    .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_pcsrc(ex_mem_pcsrc), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .flush(flush), .running(running), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy on the same stimulus exercises saturation quickly.
  pipeline_sequencer #(.HALT_OPCODE(HALT_OP), .DRAIN_CYCLES(DRAIN_N), .CNT_W(CW_SMALL)) dut_small (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
    .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .ex_mem_pcsrc(ex_mem_pcsrc), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .id_ex_bubble(s_id_ex_bubble), .flush(s_flush), .running(s_running), .halted(s_halted),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // Behavioural model
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;
  mode_t m_mode;
  int    m_drain_left;
  int    m_stall, m_flush, m_stall_s, m_flush_s;

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_drain_left = 0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  task automatic cyc(input logic run, input logic step, input logic [31:0] instr,
                     input logic memread, input logic [4:0] rt, input logic pcsrc);
    logic hz, hd, active, pw, iw, bub, fl;
    logic [5:0] ctrl_got, ctrl_s_got;
    run_req = run; step_req = step; if_id_instr = instr;
    id_ex_memread = memread; id_ex_rt = rt; ex_mem_pcsrc = pcsrc;
    hz = memread && (rt != 0) && (rt == instr[25:21] || rt == instr[20:16]);
    hd = (instr[31:26] == HALT_OP);
    active = (m_mode == M_RUN) || (m_mode == M_STEP);
    pw = 0; iw = 0; bub = 1; fl = 0;
    if (active) begin
      if (pcsrc) begin pw = 1; iw = 1; bub = 0; fl = 1; end
      else if (hz || (hd && m_mode == M_RUN)) begin pw = 0; iw = 0; bub = 1; end
      else begin pw = 1; iw = 1; bub = 0; end
    end else if (m_mode == M_DRAIN) begin
      pw = pcsrc; fl = pcsrc;
    end
    @(negedge clk);
    n_cyc++;
    ctrl_got   = {pc_write, if_id_write, id_ex_bubble, flush, running, halted};
    ctrl_s_got = {s_pc_write, s_if_id_write, s_id_ex_bubble, s_flush, s_running, s_halted};
    $display("cyc %0d mode=%s run=%b step=%b pcsrc=%b hz=%b hd=%b ctrl=%b stall=%0d flush=%0d",
             n_cyc, m_mode.name(), run, step, pcsrc, hz, hd, ctrl_got, stall_count, flush_count);
    check_val("ctrl", 32'(ctrl_got),
              32'({pw, iw, bub, fl, (m_mode == M_RUN || m_mode == M_DRAIN), (m_mode == M_HALTED)}));
    check_val("ctrl_small", 32'(ctrl_s_got), 32'(ctrl_got));
    check_val("stall_count", 32'(stall_count), 32'(m_stall));
    check_val("flush_count", 32'(flush_count), 32'(m_flush));
    check_val("stall_count_small", 32'(s_stall_count), 32'(m_stall_s));
    check_val("flush_count_small", 32'(s_flush_count), 32'(m_flush_s));
    if (active && !pcsrc && hz) begin
      m_stall = sat_inc(m_stall, MAX_BIG); m_stall_s = sat_inc(m_stall_s, MAX_SML);
    end
    if (fl) begin
      m_flush = sat_inc(m_flush, MAX_BIG); m_flush_s = sat_inc(m_flush_s, MAX_SML);
    end
    case (m_mode)
      M_IDLE:  if (run) m_mode = M_RUN; else if (step) m_mode = M_STEP;
      M_STEP:  m_mode = M_IDLE;
      M_RUN:   if (hd && !pcsrc) begin m_mode = M_DRAIN; m_drain_left = DRAIN_N; end
      M_DRAIN: begin
        if (pcsrc) m_mode = M_RUN;
        else begin
          m_drain_left--;
          if (m_drain_left == 0) m_mode = M_HALTED;
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted between edges with run_req high to show it dominates.
  task automatic do_reset();
    rst_n = 1'b0; run_req = 1'b1; step_req = 1'b1;
    #2;
    model_reset();
    check_val("rst_ctrl", 32'({pc_write, if_id_write, id_ex_bubble, flush, running, halted}),
              32'(6'b001000));
    check_val("rst_stall", 32'(stall_count), 32'd0);
    check_val("rst_flush", 32'(flush_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    run_req = 0; step_req = 0; id_ex_memread = 0; ex_mem_pcsrc = 0;
    id_ex_rt = 0; if_id_instr = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int rst_countdown;
  logic [5:0] op;
  logic [31:0] instr_r;

  initial begin
    rst_n = 1'b1;
    run_req = 0; step_req = 0; id_ex_memread = 0; ex_mem_pcsrc = 0;
    id_ex_rt = 0; if_id_instr = 0;
    model_reset();
    #1;
    do_reset();

    // Free run, stalls, flush priority, halt and sticky HALTED
    cyc(1, 0, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    repeat (3) cyc(0, 0, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    cyc(0, 0, mk(6'h00, 5'd5, 5'd3), 1, 5'd5, 0);
    cyc(0, 0, mk(6'h00, 5'd0, 5'd3), 1, 5'd0, 0);
    cyc(0, 0, mk(6'h00, 5'd5, 5'd5), 1, 5'd5, 1);
    cyc(0, 0, 32'hFC000000, 0, 5'd0, 0);
    repeat (3) cyc(0, 0, 32'h0, 0, 5'd0, 0);
    repeat (2) cyc(1, 1, 32'h0, 0, 5'd0, 0);
    do_reset();

    // Wrong-path halt cancelled in the second drain cycle
    cyc(1, 0, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    cyc(0, 0, 32'hFC000000, 0, 5'd0, 0);
    cyc(0, 0, 32'h0, 0, 5'd0, 0);
    cyc(0, 0, 32'h0, 0, 5'd0, 1);
    repeat (5) cyc(0, 0, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    do_reset();

    // Single steps, including one that ignores a halt opcode
    cyc(0, 1, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    cyc(0, 0, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    cyc(0, 1, mk(6'h00, 5'd1, 5'd2), 0, 5'd0, 0);
    cyc(0, 0, 32'hFC000000, 0, 5'd0, 0);
    cyc(0, 0, 32'h0, 0, 5'd0, 0);
    do_reset();

    // Random traffic with periodic resets
    rst_countdown = $urandom_range(300, 20);
    for (int i = 0; i < 1500; i++) begin
      if (rst_countdown == 0) begin
        do_reset();
        rst_countdown = $urandom_range(300, 20);
      end
      rst_countdown--;
      op = ($urandom % 16 == 0) ? HALT_OP : 6'($urandom_range(62, 0));
      instr_r = {op, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 16'($urandom)};
      cyc(($urandom % 8) == 0, ($urandom % 4) == 0, instr_r,
          ($urandom % 2) == 0, 5'($urandom_range(7, 0)), ($urandom % 6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
